cpu_sequencer: RTL and testbench



---
 rtl/cpu_simple_pkg.sv | 28 ++
 rtl/instr_decoder.sv | 49 ++++
 rtl/cpu_sequencer.sv | 104 ++++++++++
 tb/tb_cpu_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_simple_pkg.sv
// Shared definitions for the 4-bit simple CPU: opcodes, operand select codes, sequencer states.
package cpu_simple_pkg;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_I  = 4'b1011;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      DECODE = 2'b01,
      EXEC   = 2'b10
   } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode for the simple CPU sequencer.
// Opcode 1110 is a conditional jump only when CPU_SEQ_JNC_EN is defined, otherwise a NOP.
module instr_decoder
   import cpu_simple_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       carry_flag,
   output logic [1:0] sel,
   output logic       load_a,
   output logic       load_b,
   output logic       load_out,
   output logic       jump,
   output logic       is_add,
   output logic       zero_imm
);

   always_comb begin
      sel      = SEL_ZERO;
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_out = 1'b0;
      jump     = 1'b0;
      is_add   = 1'b0;
      zero_imm = 1'b0;
      case (opcode)
         OP_ADD_A:  begin sel = SEL_A;    load_a = 1'b1; is_add = 1'b1; end
         OP_ADD_B:  begin sel = SEL_B;    load_b = 1'b1; is_add = 1'b1; end
         OP_MOV_AI: begin sel = SEL_ZERO; load_a = 1'b1; end
         OP_MOV_BI: begin sel = SEL_ZERO; load_b = 1'b1; end
         OP_MOV_AB: begin sel = SEL_B;    load_a = 1'b1; zero_imm = 1'b1; end
         OP_MOV_BA: begin sel = SEL_A;    load_b = 1'b1; zero_imm = 1'b1; end
         OP_IN_A:   begin sel = SEL_IN;   load_a = 1'b1; zero_imm = 1'b1; end
         OP_IN_B:   begin sel = SEL_IN;   load_b = 1'b1; zero_imm = 1'b1; end
         OP_OUT_B:  begin sel = SEL_B;    load_out = 1'b1; zero_imm = 1'b1; end
         OP_OUT_I:  begin sel = SEL_ZERO; load_out = 1'b1; end
         OP_JMP:    jump = 1'b1;
`ifdef CPU_SEQ_JNC_EN
         OP_JNC:    jump = ~carry_flag;
`endif
         default: ;
      endcase
   end

`ifndef CPU_SEQ_JNC_EN
   logic unused_carry_flag;
   assign unused_carry_flag = carry_flag;
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: owns pc, instruction register and carry flag.
// Build option CPU_SEQ_JNC_EN enables JNC and the carry register.
module cpu_sequencer
   import cpu_simple_pkg::*;
#(
   parameter int unsigned PC_W    = 4,
   parameter int unsigned INSTR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [INSTR_W-1:0] instr,
   input  logic               carry_in,
   output logic [PC_W-1:0]    rom_addr,
   output logic [1:0]         sel,
   output logic [3:0]         imm,
   output logic               load_a,
   output logic               load_b,
   output logic               load_out,
   output logic               load_pc,
   output logic               carry_flag,
   output logic [1:0]         state_o
);

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] ir_q;
   logic [PC_W-1:0]    pc_q;
   logic               dec_load_a, dec_load_b, dec_load_out, dec_jump;
   logic               is_add, zero_imm, exec;

   instr_decoder u_instr_decoder (
      .opcode     (ir_q[INSTR_W-1 -: 4]),
      .carry_flag (carry_flag),
      .sel        (sel),
      .load_a     (dec_load_a),
      .load_b     (dec_load_b),
      .load_out   (dec_load_out),
      .jump       (dec_jump),
      .is_add     (is_add),
      .zero_imm   (zero_imm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         ir_q    <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FETCH && run) begin
            ir_q <= instr;
         end
         if (exec) begin
            pc_q <= dec_jump ? PC_W'(ir_q[3:0]) : pc_q + PC_W'(1);
         end
      end
   end

   // Strobes are gated by EXEC so reset drops them combinationally.
   always_comb begin
      state_d  = FETCH;
      exec     = 1'b0;
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_out = 1'b0;
      load_pc  = 1'b0;
      case (state_q)
         FETCH:  state_d = run ? DECODE : FETCH;
         DECODE: state_d = EXEC;
         EXEC: begin
            state_d  = FETCH;
            exec     = 1'b1;
            load_a   = dec_load_a;
            load_b   = dec_load_b;
            load_out = dec_load_out;
            load_pc  = dec_jump;
         end
         default: state_d = FETCH;
      endcase
   end

`ifdef CPU_SEQ_JNC_EN
   logic carry_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q <= 1'b0;
      end else if (exec) begin
         carry_q <= is_add & carry_in;
      end
   end

   assign carry_flag = carry_q;
`else
   logic unused_carry;
   assign unused_carry = carry_in ^ is_add;
   assign carry_flag   = 1'b0;
`endif

   assign imm      = zero_imm ? 4'h0 : ir_q[3:0];
   assign rom_addr = pc_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed vector bench for cpu_sequencer; ROM modelled as a 16-entry array.
module tb_cpu_sequencer;

`ifdef CPU_SEQ_JNC_EN
   localparam bit JNC_EN = 1'b1;
`else
   localparam bit JNC_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] ins;
      logic       cin;
      logic [1:0] sel;
      logic [3:0] imm;
      logic       la;
      logic       lb;
      logic       lo;
      logic       lpc;
      logic       carry;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [7:0] instr;
   logic       carry_in = 1'b0;
   logic [3:0] rom_addr;
   logic [1:0] sel;
   logic [3:0] imm;
   logic       load_a, load_b, load_out, load_pc, carry_flag;
   logic [1:0] state_o;

   logic [7:0] rom [16];
   logic [3:0] exp_pc;
   int         checks = 0;
   int         errors = 0;
   vec_t       vecs [17];

   always #5 clk = ~clk;
   assign instr = rom[rom_addr];

   cpu_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .instr      (instr),
      .carry_in   (carry_in),
      .rom_addr   (rom_addr),
      .sel        (sel),
      .imm        (imm),
      .load_a     (load_a),
      .load_b     (load_b),
      .load_out   (load_out),
      .load_pc    (load_pc),
      .carry_flag (carry_flag),
      .state_o    (state_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] ins, input logic cin, input logic [1:0] s,
                               input logic [3:0] im, input logic la, input logic lb,
                               input logic lo, input logic lpc, input logic cy);
      vec_t v;
      v.ins = ins; v.cin = cin; v.sel = s; v.imm = im;
      v.la = la; v.lb = lb; v.lo = lo; v.lpc = lpc; v.carry = cy;
      return v;
   endfunction

   // Entered #1 after a posedge with the DUT in FETCH; drops run during DECODE.
   task automatic run_instr(input vec_t v, input string tag);
      logic [3:0] nxt;
      rom[exp_pc] = v.ins;
      carry_in    = v.cin;
      run         = 1'b1;
      @(posedge clk); #1;
      chk({tag, " decode state"}, 32'(state_o), 32'd1);
      chk({tag, " decode strobes"}, 32'({load_a, load_b, load_out, load_pc}), 32'd0);
      run = 1'b0;
      @(posedge clk); #1;
      chk({tag, " exec state"}, 32'(state_o), 32'd2);
      chk({tag, " exec sel"}, 32'(sel), 32'(v.sel));
      chk({tag, " exec imm"}, 32'(imm), 32'(v.imm));
      chk({tag, " exec strobes"}, 32'({load_a, load_b, load_out, load_pc}),
          32'({v.la, v.lb, v.lo, v.lpc}));
      chk({tag, " exec rom_addr"}, 32'(rom_addr), 32'(exp_pc));
      nxt = v.lpc ? v.imm : exp_pc + 4'd1;
      @(posedge clk); #1;
      chk({tag, " fetch state"}, 32'(state_o), 32'd0);
      chk({tag, " next pc"}, 32'(rom_addr), 32'(nxt));
      chk({tag, " carry"}, 32'(carry_flag), 32'(v.carry));
      chk({tag, " fetch strobes"}, 32'({load_a, load_b, load_out, load_pc}), 32'd0);
      exp_pc = nxt;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 8'h80;
      exp_pc = 4'd0;

      //        ins    cin  sel    imm   la lb lo lpc     carry
      vecs[0]  = mk(8'h35, 0, 2'd3, 4'h5, 1, 0, 0, 0,      0);
      vecs[1]  = mk(8'h73, 0, 2'd3, 4'h3, 0, 1, 0, 0,      0);
      vecs[2]  = mk(8'hF7, 0, 2'd3, 4'h7, 0, 0, 0, 1,      0);
      vecs[3]  = mk(8'h10, 0, 2'd1, 4'h0, 1, 0, 0, 0,      0);
      vecs[4]  = mk(8'h40, 0, 2'd0, 4'h0, 0, 1, 0, 0,      0);
      vecs[5]  = mk(8'h20, 0, 2'd2, 4'h0, 1, 0, 0, 0,      0);
      vecs[6]  = mk(8'h60, 0, 2'd2, 4'h0, 0, 1, 0, 0,      0);
      vecs[7]  = mk(8'h90, 0, 2'd1, 4'h0, 0, 0, 1, 0,      0);
      vecs[8]  = mk(8'hB9, 0, 2'd3, 4'h9, 0, 0, 1, 0,      0);
      vecs[9]  = mk(8'h01, 1, 2'd0, 4'h1, 1, 0, 0, 0,      JNC_EN);
      vecs[10] = mk(8'hE4, 0, 2'd3, 4'h4, 0, 0, 0, 0,      0);
      vecs[11] = mk(8'h83, 0, 2'd3, 4'h3, 0, 0, 0, 0,      0);
      vecs[12] = mk(8'h52, 0, 2'd1, 4'h2, 0, 1, 0, 0,      0);
      vecs[13] = mk(8'hE4, 0, 2'd3, 4'h4, 0, 0, 0, JNC_EN, 0);
      vecs[14] = mk(8'h5F, 1, 2'd1, 4'hF, 0, 1, 0, 0,      JNC_EN);
      vecs[15] = mk(8'h35, 1, 2'd3, 4'h5, 1, 0, 0, 0,      0);
      vecs[16] = mk(8'h0E, 1, 2'd0, 4'hE, 1, 0, 0, 0,      JNC_EN);

      #2;
      chk("reset state", 32'(state_o), 32'd0);
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset carry", 32'(carry_flag), 32'd0);
      chk("reset sel", 32'(sel), 32'd0);
      chk("reset imm", 32'(imm), 32'd0);
      chk("reset strobes", 32'({load_a, load_b, load_out, load_pc}), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Stall at FETCH with run low.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall state", 32'(state_o), 32'd0);
         chk("stall strobes", 32'({load_a, load_b, load_out, load_pc}), 32'd0);
         chk("stall pc", 32'(rom_addr), 32'd0);
      end

      for (int i = 0; i < 17; i++) begin
         run_instr(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of EXEC of MOV A,5.
      rom[exp_pc] = 8'h35;
      carry_in    = 1'b0;
      run         = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset load_a", 32'(load_a), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid-exec reset load_a", 32'(load_a), 32'd0);
      chk("mid-exec reset state", 32'(state_o), 32'd0);
      chk("mid-exec reset pc", 32'(rom_addr), 32'd0);
      chk("mid-exec reset carry", 32'(carry_flag), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      exp_pc = 4'd0;
      run_instr(vecs[0], "post-reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
